online_to_binary_converter: RTL and testbench

//  Consumes the radix-2 signed-digit stream from the online adder, most significant digit first.

---
 rtl/online_to_binary_converter.sv | 131 +++++++++++++
 tb/tb_online_to_binary_converter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/online_to_binary_converter.sv
// On-the-fly converter: MSD-first radix-2 signed digits -> (NDIGITS+1)-bit two's-complement word.
// Optional OTFC_ZERO_FLAG_EN adds a registered res_zero flag alongside res.
module online_to_binary_converter #(
  parameter int NDIGITS = 8,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               syn_reset,
  input  logic [1:0]         digit,
  input  logic               digit_vld,
  output logic               digit_rdy,
  output logic [NDIGITS:0]   res,
  output logic               res_vld,
`ifdef OTFC_ZERO_FLAG_EN
  output logic               res_zero,
`endif
  input  logic               res_rdy
);

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(NDIGITS - 1);
  localparam logic [NDIGITS:0]   ONE      = (NDIGITS+1)'(1);
  localparam logic [NDIGITS:0]   ALL_ONES = '1;

  typedef enum logic [1:0] {
    COLLECT = 2'b01,
    DONE    = 2'b10
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NDIGITS:0]   q, q_nxt, q_upd;
  logic [NDIGITS:0]   qm, qm_nxt, qm_upd;
  logic [NDIGITS:0]   res_nxt;
  logic               res_vld_nxt;
`ifdef OTFC_ZERO_FLAG_EN
  logic               res_zero_nxt;
`endif

  // Q/QM pair: QM tracks Q-1, so a -1 digit selects from QM instead of borrowing.
  always_comb begin
    q_upd  = q << 1;
    qm_upd = (qm << 1) | ONE;
    case (digit)
      2'b10: begin
        q_upd  = (q << 1) | ONE;
        qm_upd = q << 1;
      end
      2'b01: begin
        q_upd  = (qm << 1) | ONE;
        qm_upd = qm << 1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    q_nxt       = q;
    qm_nxt      = qm;
    res_nxt     = res;
    res_vld_nxt = res_vld;
    digit_rdy   = 1'b0;
`ifdef OTFC_ZERO_FLAG_EN
    res_zero_nxt = res_zero;
`endif
    case (state)
      COLLECT: begin
        digit_rdy = 1'b1;
        if (digit_vld) begin
          q_nxt   = q_upd;
          qm_nxt  = qm_upd;
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            res_nxt     = q_upd;
            res_vld_nxt = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = DONE;
`ifdef OTFC_ZERO_FLAG_EN
            res_zero_nxt = (q_upd == '0);
`endif
          end
        end
      end
      DONE: begin
        if (res_vld && res_rdy) begin
          res_vld_nxt = 1'b0;
          q_nxt       = '0;
          qm_nxt      = ALL_ONES;
          state_nxt   = COLLECT;
        end
      end
      default: begin
        state_nxt   = COLLECT;
        cnt_nxt     = '0;
        q_nxt       = '0;
        qm_nxt      = ALL_ONES;
        res_nxt     = '0;
        res_vld_nxt = 1'b0;
`ifdef OTFC_ZERO_FLAG_EN
        res_zero_nxt = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (syn_reset) begin
      state    <= COLLECT;
      cnt      <= '0;
      q        <= '0;
      qm       <= ALL_ONES;
      res      <= '0;
      res_vld  <= 1'b0;
`ifdef OTFC_ZERO_FLAG_EN
      res_zero <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      q        <= q_nxt;
      qm       <= qm_nxt;
      res      <= res_nxt;
      res_vld  <= res_vld_nxt;
`ifdef OTFC_ZERO_FLAG_EN
      res_zero <= res_zero_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_online_to_binary_converter.sv
// Randomized self-checking bench: reference is a Horner sum of decoded digits per frame.
module tb_online_to_binary_converter;
  localparam int NDIGITS = 8;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             syn_reset = 1'b1;
  logic [1:0]       digit = 2'b00;
  logic             digit_vld = 1'b0;
  logic             digit_rdy;
  logic [NDIGITS:0] res;
  logic             res_vld;
  logic             res_rdy = 1'b0;
`ifdef OTFC_ZERO_FLAG_EN
  logic             res_zero;
`endif

  online_to_binary_converter #(.NDIGITS(NDIGITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .syn_reset(syn_reset), .digit(digit), .digit_vld(digit_vld),
    .digit_rdy(digit_rdy), .res(res), .res_vld(res_vld),
`ifdef OTFC_ZERO_FLAG_EN
    .res_zero(res_zero),
`endif
    .res_rdy(res_rdy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int model_acc = 0;
  int model_n   = 0;
  int exp_q[$];
  int cur_exp   = 0;
  logic prev_vld = 1'b0;
  int frames_seen = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dval(input logic [1:0] d);
    if (d == 2'b10) return 1;
    if (d == 2'b01) return -1;
    return 0;
  endfunction

  // One clock: drive inputs, advance, update model, check any visible result.
  task automatic cycle(input logic vld, input logic [1:0] d, input logic rdy, output logic took);
    logic acc_now;
    digit_vld = vld;
    digit     = d;
    res_rdy   = rdy;
    acc_now   = vld && digit_rdy;
    @(posedge clk); #1;
    took = acc_now;
    if (acc_now) begin
      model_acc = model_acc * 2 + dval(d);
      model_n++;
      if (model_n == NDIGITS) begin
        exp_q.push_back(model_acc);
        model_acc = 0;
        model_n   = 0;
      end
    end
    check_eq("rdy_vs_vld", int'(digit_rdy), int'(!res_vld));
    if (res_vld && !prev_vld) begin
      frames_seen++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_res", 1, 0);
        cur_exp = 0;
      end else begin
        cur_exp = exp_q.pop_front();
      end
    end
    if (res_vld) begin
      check_eq("res", int'($signed(res)), cur_exp);
`ifdef OTFC_ZERO_FLAG_EN
      check_eq("res_zero", int'(res_zero), int'(cur_exp == 0));
`endif
    end
    prev_vld = res_vld;
  endtask

  task automatic send_digit(input logic [1:0] d);
    logic took;
    int t;
    t = 0;
    took = 1'b0;
    while (!took && t < 50) begin
      cycle(1'b1, d, 1'b1, took);
      t++;
    end
    if (!took) check_eq("send_timeout", 0, 1);
  endtask

  task automatic send_frame(input logic [1:0] d0, input logic [1:0] d_rest);
    send_digit(d0);
    for (int i = 1; i < NDIGITS; i++) send_digit(d_rest);
  endtask

  task automatic do_reset();
    digit_vld = 1'b0;
    syn_reset = 1'b1;
    @(posedge clk); #1;
    syn_reset = 1'b0;
    model_acc = 0;
    model_n   = 0;
    exp_q.delete();
    prev_vld  = 1'b0;
  endtask

  task automatic idle(input int n);
    logic took;
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 1'b1, took);
  endtask

  initial begin
    logic took;
    int budget;
    @(posedge clk); #1;
    do_reset();
    check_eq("rst_res", int'(res), 0);
    check_eq("rst_vld", int'(res_vld), 0);
    check_eq("rst_rdy", int'(digit_rdy), 1);
`ifdef OTFC_ZERO_FLAG_EN
    check_eq("rst_zero", int'(res_zero), 0);
`endif

    // eight +1: single-cycle res_vld with res_rdy high
    send_frame(2'b10, 2'b10);
    check_eq("t1_vld", int'(res_vld), 1);
    check_eq("t1_rdy", int'(digit_rdy), 0);
    check_eq("t1_res", int'(res), 'h0FF);
    cycle(1'b0, 2'b00, 1'b1, took);
    check_eq("t1_vld_drop", int'(res_vld), 0);
    check_eq("t1_res_kept", int'(res), 'h0FF);

    send_frame(2'b10, 2'b01);
    check_eq("t2a_res", int'(res), 'h001);
    idle(1);
    send_frame(2'b01, 2'b01);
    check_eq("t2b_res", int'(res), 'h101);
    idle(1);

    for (int i = 0; i < NDIGITS; i++) send_digit((i % 2 == 0) ? 2'b00 : 2'b11);
    check_eq("t3_res", int'(res), 0);
`ifdef OTFC_ZERO_FLAG_EN
    check_eq("t3_zero", int'(res_zero), 1);
`endif
    idle(1);

    // backpressure: a held -1 must not be consumed while DONE
    send_frame(2'b10, 2'b10);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 2'b01, 1'b0, took);
      check_eq("t4_not_taken", int'(took), 0);
      check_eq("t4_vld", int'(res_vld), 1);
      check_eq("t4_res", int'(res), 'h0FF);
    end
    cycle(1'b1, 2'b01, 1'b1, took);
    check_eq("t4_xfer_not_taken", int'(took), 0);
    check_eq("t4_vld_drop", int'(res_vld), 0);
    send_frame(2'b10, 2'b10);
    check_eq("t4_next_res", int'(res), 'h0FF);
    idle(1);

    // mid-frame reset
    send_digit(2'b01);
    send_digit(2'b11);
    send_digit(2'b01);
    do_reset();
    check_eq("t6_rst_vld", int'(res_vld), 0);
    check_eq("t6_rst_rdy", int'(digit_rdy), 1);
    send_frame(2'b10, 2'b10);
    check_eq("t6_res", int'(res), 'h0FF);
    idle(1);

    // randomized traffic
    frames_seen = 0;
    budget = 0;
    while (frames_seen < 200 && budget < 20000) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0), took);
      budget++;
    end
    check_eq("t5_frames", int'(frames_seen >= 200), 1);
    idle(3);
    check_eq("t5_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
